dht11_responder: RTL

Single-wire DHT11 sensor emulator: the responder end of the bus our `DHT11` host controller drives. It watches `dht11_data` for a host start pulse. It then answers with the standard DHT11 handshake and a 40-bit frame built from the `humidity`/`temperature` inputs, and releases the bus when done. It is used for board loopback of the fan controller and as the sensor model in benches.

---
 rtl/dht11_pkg.sv | 34 +++
 rtl/dht11_responder_us_tick_gen.sv | 31 +++
 rtl/dht11_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: definitions shared by the DHT11 host controller and the responder.
//   dht11_state_t - responder state encoding
//   *_US          - fixed protocol phase lengths in microseconds
//   FRAME_BITS    - data frame width
//   build_frame   - assembles the 40-bit frame including the checksum
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_TURN,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht11_state_t;

  localparam int unsigned ACK_US     = 80;
  localparam int unsigned BIT_LOW_US = 50;
  localparam int unsigned BIT0_US    = 26;
  localparam int unsigned BIT1_US    = 70;
  localparam int unsigned END_US     = 50;
  localparam int unsigned FRAME_BITS = 40;

  // Frame layout MSB first: humidity, 0, temperature, 0, checksum (mod 256).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] hum,
                                                        input logic [7:0] temp);
    logic [7:0] csum;
    csum = hum + temp;
    return {hum, 8'h00, temp, 8'h00, csum};
  endfunction

endpackage

// File: rtl/dht11_responder_us_tick_gen.sv
// us_tick_gen: microsecond tick generator.
//   clk, reset_p - clock, asynchronous active-high reset
//   clr          - restart the current microsecond from zero
//   tick_us      - one-cycle pulse in the last clock of every microsecond
module us_tick_gen #(
  parameter int unsigned CLK_FREQ_MHZ = 100
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick_us
);

  localparam int unsigned CW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_MHZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_us = (cnt_q == LAST);

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: single-wire DHT11 sensor emulator.
//   clk, reset_p        - clock, asynchronous active-high reset
//   dht11_data          - open-drain bus, driven 0 or released (external pull-up)
//   humidity            - humidity byte to report
//   temperature         - temperature byte to report
//   busy                - high from start acceptance until the end of the frame
//   frame_done          - one-cycle pulse as the block returns to idle after a frame
module dht11_responder #(
  parameter int unsigned CLK_FREQ_MHZ  = 100,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned TURNAROUND_US = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  inout  wire        dht11_data,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  output logic       busy,
  output logic       frame_done
);
  import dht11_pkg::*;

  localparam int unsigned US_MAX_A = (START_MIN_US > TURNAROUND_US) ? START_MIN_US : TURNAROUND_US;
  localparam int unsigned US_MAX   = (US_MAX_A > ACK_US) ? US_MAX_A : ACK_US;
  localparam int unsigned US_W     = $clog2(US_MAX + 1) + 1;

  dht11_state_t          state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  din_prev_q;
  logic [US_W-1:0]       us_q, us_d;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  oe_q, oe_d;
  logic                  done_q, done_d;
  logic                  din, tick, entry, phase_end;
  int unsigned           phase_len;

  assign sync_d = {sync_q[0], dht11_data};
  assign din    = sync_q[1];

  us_tick_gen #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (entry),
    .tick_us (tick)
  );

  always_comb begin
    phase_len = 1;
    unique case (state_q)
      ST_TURN:                  phase_len = TURNAROUND_US;
      ST_ACK_LOW, ST_ACK_HIGH:  phase_len = ACK_US;
      ST_BIT_LOW:               phase_len = BIT_LOW_US;
      ST_BIT_HIGH:              phase_len = frame_q[bit_idx_q] ? BIT1_US : BIT0_US;
      ST_END_LOW:               phase_len = END_US;
      default:                  phase_len = 1;
    endcase
    // Phase ends on the tick closing its last microsecond, so each phase
    // occupies exactly N * CLK_FREQ_MHZ clocks from its entry edge.
    phase_end = tick && (32'(us_q) == phase_len - 1);
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (din_prev_q && !din) state_d = ST_HOST_LOW;
      ST_HOST_LOW:
        if (din) begin
          if (32'(us_q) >= START_MIN_US) begin
            state_d = ST_TURN;
            frame_d = build_frame(humidity, temperature);
          end else begin
            state_d = ST_IDLE;
          end
        end
      ST_TURN:
        if (phase_end) state_d = ST_ACK_LOW;
      ST_ACK_LOW:
        if (phase_end) state_d = ST_ACK_HIGH;
      ST_ACK_HIGH:
        if (phase_end) begin
          state_d   = ST_BIT_LOW;
          bit_idx_d = 6'(FRAME_BITS - 1);
        end
      ST_BIT_LOW:
        if (phase_end) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH:
        if (phase_end) begin
          if (bit_idx_q == '0) begin
            state_d = ST_END_LOW;
          end else begin
            state_d   = ST_BIT_LOW;
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end
      ST_END_LOW:
        if (phase_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase

    entry = (state_d != state_q);

    // Microsecond counter: restarts on every state entry and saturates.
    us_d = us_q;
    if (entry)                  us_d = '0;
    else if (tick && us_q != '1) us_d = us_q + 1'b1;

    // Registered decode of the next state keeps din out of the drive path.
    oe_d = (state_d == ST_ACK_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      din_prev_q <= 1'b1;
      us_q       <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      din_prev_q <= din;
      us_q       <= us_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
    end
  end

  assign dht11_data = oe_q ? 1'b0 : 1'bz;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HOST_LOW);
  assign frame_done = done_q;

endmodule
